// File: rtl/uart_autobaud.sv
// UART auto-baud detector: times a 0x55 calibration character
// and derives the 1/16-bit divisor for the baud rate generator.
module uart_autobaud #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [22:0] TIMEOUT     = 23'h7FFFFF
) (
  input  logic        uart_clk_i,
  input  logic        uart_rst_n_i,
  input  logic        rx_i,
  input  logic        start_i,
  input  logic [15:0] default_div_i,
  output logic [15:0] baud_div_o,
  output logic        locked_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    MEASURE
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  logic [22:0]            cnt_q;
  logic [1:0]             edge_q;
  logic [15:0]            meas_q;
  logic                   locked_q;
  logic                   err_q;
  logic                   done_q;

  logic        rx_s;
  logic        fall;
  logic [23:0] n_d;
  logic [23:0] div_d;
  logic        div_ok;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_prev_q & ~rx_s;

  // cnt counts from the start edge, so N is cnt+1 at the 4th edge
  assign n_d    = {1'b0, cnt_q} + 24'd1;
  assign div_d  = (n_d + 24'd64) >> 7;
  assign div_ok = (div_d != 24'd0) && (div_d <= 24'h00FFFF);

  always_ff @(posedge uart_clk_i or negedge uart_rst_n_i) begin
    if (!uart_rst_n_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  always_ff @(posedge uart_clk_i or negedge uart_rst_n_i) begin
    if (!uart_rst_n_i) begin
      state_q   <= IDLE;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      edge_q    <= '0;
      meas_q    <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rx_prev_q <= rx_s;
      done_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q  <= WAIT_START;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
          end
        end
        WAIT_START: begin
          if (fall) begin
            state_q <= MEASURE;
            cnt_q   <= '0;
            edge_q  <= '0;
          end
        end
        MEASURE: begin
          cnt_q <= cnt_q + 23'd1;
          if (fall && edge_q == 2'd3) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            if (div_ok) begin
              meas_q   <= div_d[15:0];
              locked_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (cnt_q == TIMEOUT) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (fall) begin
            edge_q <= edge_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q == WAIT_START) || (state_q == MEASURE);
  assign baud_div_o = locked_q ? meas_q : default_div_i;
  assign locked_o   = locked_q;
  assign err_o      = err_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Bench for uart_autobaud: 0x55 frames at assorted bit periods
// compared with an arithmetic model of the divisor.
module tb_uart_autobaud;

  localparam int          SS = 2;
  localparam logic [22:0] TO = 23'd8000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ddiv = 16'd54;
  logic [15:0] bdiv;
  logic        locked;
  logic        busy;
  logic        err;
  logic        done;

  uart_autobaud #(
    .SYNC_STAGES(SS),
    .TIMEOUT    (TO)
  ) dut (
    .uart_clk_i   (clk),
    .uart_rst_n_i (rst_n),
    .rx_i         (rx),
    .start_i      (start),
    .default_div_i(ddiv),
    .baud_div_o   (bdiv),
    .locked_o     (locked),
    .busy_o       (busy),
    .err_o        (err),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int fall_cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // 8 bit times from start edge to the bit-7 falling edge
  function automatic int exp_div(int b);
    return (8 * b + 64) / 128;
  endfunction

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(int b, int lo, int hi);
    logic [9:0] fr;
    fr = {1'b1, 8'h55, 1'b0};
    for (int i = lo; i <= hi; i++) begin
      rx = fr[i];
      if (i == 8) fall_cyc = cyc;
      repeat (b) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic run_frame(int b, logic [15:0] dv, string tag);
    int d0;
    int e;
    d0   = done_cnt;
    ddiv = dv;
    e    = exp_div(b);
    pulse_start();
    check({tag, "_busy"}, busy, 1);
    check({tag, "_unlock"}, locked, 0);
    send(b, 0, 9);
    idle(8);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_lat"}, done_cyc - fall_cyc, SS + 1);
    check({tag, "_busy_end"}, busy, 0);
    if (e >= 1 && e <= 65535) begin
      check({tag, "_locked"}, locked, 1);
      check({tag, "_err"}, err, 0);
      check({tag, "_div"}, bdiv, e);
    end else begin
      check({tag, "_locked"}, locked, 0);
      check({tag, "_err"}, err, 1);
      check({tag, "_div"}, bdiv, dv);
    end
  endtask

  initial begin
    int d0;
    int c0;
    int lat;
    int bl[$];

    #2;
    check("rst_div", bdiv, 54);
    check("rst_locked", locked, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);
    #11 rst_n = 1'b1;
    idle(3);

    run_frame(868, 16'd54, "b115200");

    ddiv = 16'd77;
    d0 = done_cnt;
    pulse_start();
    check("restart_unlock", locked, 0);
    check("restart_div", bdiv, 77);
    send(868, 0, 4);
    pulse_start();
    check("ign_busy", busy, 1);
    send(868, 5, 9);
    idle(8);
    check("ign_done", done_cnt - d0, 1);
    check("ign_locked", locked, 1);
    check("ign_div", bdiv, 54);

    bl = '{4, 7, 8};
    for (int i = 0; i < 5; i++) bl.push_back($urandom_range(9, 300));
    foreach (bl[i]) begin
      run_frame(bl[i], 16'($urandom_range(1, 65535)), "rand");
      idle(5);
    end

    d0 = done_cnt;
    ddiv = 16'd54;
    pulse_start();
    send(50, 0, 4);
    idle(5);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_locked", locked, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_div", bdiv, 54);
    #2 rst_n = 1'b1;
    idle(1);
    send(50, 5, 9);
    idle(10);
    check("mid_no_done", done_cnt - d0, 0);
    check("mid_idle", busy, 0);
    run_frame(868, 16'd54, "post_rst");

    d0 = done_cnt;
    ddiv = 16'd300;
    pulse_start();
    rx = 1'b0;
    c0 = cyc;
    for (int i = 0; i < int'(TO) + 100; i++) begin
      if (done_cnt != d0) break;
      idle(1);
    end
    idle(2);
    lat = done_cyc - c0;
    check("to_done", done_cnt - d0, 1);
    check("to_lat", (lat >= int'(TO) + SS + 1) && (lat <= int'(TO) + SS + 2), 1);
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    check("to_locked", locked, 0);
    check("to_div", bdiv, 300);
    rx = 1'b1;
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
